riscv_id_queue: RTL and testbench
=================================

RISCV_ID_QUEUE -- requirements
Module: riscv_id_queue

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the datapath width of PC and immediate (legal values 32, 64).
REQ-002 Parameter DEPTH, default 4, SHALL set the number of decoded-instruction entries (legal values 2..16).
REQ-003 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the reset, asynchronous, active-low.
REQ-005 i_flush  input  1  SHALL request discard of all queued entries.
REQ-006 i_instr_valid  input  1  SHALL qualify i_instr/i_pc from fetch.
REQ-007 o_instr_ready  output  1  SHALL indicate the queue accepts an instruction this cycle.
REQ-008 i_instr  input  32  SHALL carry the raw RV32 instruction word.
REQ-009 i_pc  input  XLEN  SHALL carry the instruction address.
REQ-010 o_valid  output  1  SHALL indicate o_dec holds a valid head entry.
REQ-011 i_ready  input  1  SHALL indicate the EX stage consumes the head entry.
REQ-012 o_dec  output  id_dec_t  SHALL carry the decoded head entry: pc, opcode, funct3, funct7, imm_num, src1/src2 en+addr, dst en+addr, jal, jalr, branch, memory2reg, mem_write, alures2reg, muldiv, illegal.
REQ-013 o_count  output  $clog2(DEPTH+1)  SHALL report the current occupancy.

Function
REQ-014 Decode SHALL be combinational on i_instr at push time; the stored entry SHALL be the decoded result, not the raw word.
REQ-015 Instruction type SHALL follow opcode: LUI/AUIPC U, JAL J, JALR/LOAD/ALI I, BRANCH B, STORE S, ALR R; any other opcode SHALL set illegal=1.
REQ-016 imm_num SHALL be the RV32I I/S/B/U/J immediate, sign-extended from instr[31] to XLEN; R type and illegal SHALL give 0.
REQ-017 src enables: R/S/B 2'b11, I 2'b01, U/J/illegal 2'b00 ({src2,src1}).
REQ-018 dst_en SHALL be 1 for U, J, I (incl. LOAD, JALR) and R types only, and SHALL be forced 0 when rd==x0.
REQ-019 An illegal entry SHALL have every enable and control flag 0 except illegal; it is still queued, not dropped.
REQ-020 o_instr_ready SHALL equal (count != DEPTH); push = i_instr_valid && o_instr_ready.
REQ-021 o_valid SHALL equal (count != 0); pop = o_valid && i_ready.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; no write-through bypass: a pushed entry appears on o_dec no earlier than the next cycle.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; DEPTH need not be a power of two.
REQ-024 o_dec SHALL remain stable while o_valid && !i_ready.
REQ-025 i_flush SHALL zero count and pointers at the next edge, overriding any same-cycle push or pop; the pushed instruction is discarded.

Reset
REQ-026 While i_rst_n is low: count=0, pointers=0, o_valid=0, o_instr_ready=0; o_dec contents SHALL be don't-care but X-free (storage reset to 0).
REQ-027 o_instr_ready SHALL assert on the first rising edge after reset release; reset mid-operation SHALL discard all entries.

Configuration
REQ-028 With macro RISCV_ID_MEXT_EN defined, opcode ALR with funct7=7'b0000001 SHALL decode legal, R type, muldiv=1.
REQ-029 Without RISCV_ID_MEXT_EN, that encoding SHALL set illegal=1 and muldiv SHALL be constant 0.

Structure
REQ-030 Opcode constants, instruction-type enum and id_dec_t (XLEN-parameterised via package parameter) SHALL live in shared package riscv_pkg.
REQ-031 Pure decode logic SHALL be sub-module riscv_id_dec; riscv_id_queue instantiates it plus the storage and pointers.

Verification
REQ-032 Reset, push 0x00500093 (addi x1,x0,5) pc 0x100, i_ready=1 -> next cycle o_valid=1, imm 5, rd 1, dst_en 1, src en 2'b01, pc 0x100.
REQ-033 Push 0xffc12283 (lw x5,-4(x2)) -> imm 0xFFFFFFFC, memory2reg 1, src1 addr 2, dst addr 5; push 0x008000ef -> jal 1, imm 8.
REQ-034 DEPTH=4, i_ready=0, push 5 consecutive -> o_instr_ready low after 4th, count 4, 5th not stored; then i_ready=1 -> entries pop in order, count reaches 0.
REQ-035 Count 3, assert i_flush with simultaneous push and pop -> next cycle count 0, o_valid 0.
REQ-036 Push 0x022081b3 (mul x3,x1,x2) -> illegal 1 without RISCV_ID_MEXT_EN; muldiv 1, illegal 0 with it; push 0x00000000 -> illegal 1.
REQ-037 Count 2, drop i_rst_n asynchronously mid-cycle -> o_valid and o_instr_ready 0 immediately, count 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcode constants, instruction-type enum and
// the decoded-entry struct carried through the ID queue.
package riscv_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALI    = 7'b0010011;
  localparam logic [6:0] OP_ALR    = 7'b0110011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IT_R,
    IT_I,
    IT_S,
    IT_B,
    IT_U,
    IT_J,
    IT_ILL
  } instr_type_e;

  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RV_XLEN-1:0] imm_num;
    logic [1:0]         src_en;     // {src2, src1}
    logic [4:0]         src1_addr;
    logic [4:0]         src2_addr;
    logic               dst_en;
    logic [4:0]         dst_addr;
    logic               jal;
    logic               jalr;
    logic               branch;
    logic               memory2reg;
    logic               mem_write;
    logic               alures2reg;
    logic               muldiv;
    logic               illegal;
  } id_dec_t;

endpackage

// File: rtl/riscv_id_dec.sv
// Combinational RV32I decoder producing one id_dec_t entry.
// RISCV_ID_MEXT_EN: when defined, OP_ALR with funct7=0000001 decodes as muldiv.
module riscv_id_dec
  import riscv_pkg::*;
(
  input  logic [31:0]        i_instr,
  input  logic [RV_XLEN-1:0] i_pc,
  output id_dec_t            o_dec
);

  instr_type_e itype;
  logic [6:0]  opcode;
  logic [31:0] imm32;
  logic        is_muldiv;

  assign opcode    = i_instr[6:0];
  assign is_muldiv = (opcode == OP_ALR) && (i_instr[31:25] == FUNCT7_MULDIV);

  always_comb begin
    itype = IT_ILL;
    case (opcode)
      OP_LUI, OP_AUIPC:         itype = IT_U;
      OP_JAL:                   itype = IT_J;
      OP_JALR, OP_LOAD, OP_ALI: itype = IT_I;
      OP_BRANCH:                itype = IT_B;
      OP_STORE:                 itype = IT_S;
      OP_ALR:                   itype = IT_R;
      default:                  itype = IT_ILL;
    endcase
`ifndef RISCV_ID_MEXT_EN
    if (is_muldiv) itype = IT_ILL;
`endif
  end

  always_comb begin
    imm32 = '0;
    case (itype)
      IT_I: imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IT_S: imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IT_B: imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                     i_instr[30:25], i_instr[11:8], 1'b0};
      IT_U: imm32 = {i_instr[31:12], 12'h000};
      IT_J: imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                     i_instr[20], i_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    o_dec           = '0;
    o_dec.pc        = i_pc;
    o_dec.opcode    = opcode;
    o_dec.funct3    = i_instr[14:12];
    o_dec.funct7    = i_instr[31:25];
    o_dec.src1_addr = i_instr[19:15];
    o_dec.src2_addr = i_instr[24:20];
    o_dec.dst_addr  = i_instr[11:7];
    o_dec.imm_num   = RV_XLEN'($signed(imm32));
    o_dec.illegal   = (itype == IT_ILL);
    case (itype)
      IT_R, IT_S, IT_B: o_dec.src_en = 2'b11;
      IT_I:             o_dec.src_en = 2'b01;
      default:          o_dec.src_en = 2'b00;
    endcase
    o_dec.dst_en = (itype inside {IT_U, IT_J, IT_I, IT_R}) && (i_instr[11:7] != 5'd0);
    if (itype != IT_ILL) begin
      o_dec.jal        = (opcode == OP_JAL);
      o_dec.jalr       = (opcode == OP_JALR);
      o_dec.branch     = (opcode == OP_BRANCH);
      o_dec.memory2reg = (opcode == OP_LOAD);
      o_dec.mem_write  = (opcode == OP_STORE);
      o_dec.alures2reg = opcode inside {OP_LUI, OP_AUIPC, OP_ALI, OP_ALR};
    end
`ifdef RISCV_ID_MEXT_EN
    o_dec.muldiv = is_muldiv;
`endif
  end

endmodule

// File: rtl/riscv_id_queue.sv
// Decoded-instruction queue between fetch and EX: decodes at push, stores
// DEPTH entries in a circular buffer. Optional macro: RISCV_ID_MEXT_EN.
module riscv_id_queue
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = RV_XLEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_instr_valid,
  output logic                       o_instr_ready,
  input  logic [31:0]                i_instr,
  input  logic [XLEN-1:0]            i_pc,
  output logic                       o_valid,
  input  logic                       i_ready,
  output id_dec_t                    o_dec,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  id_dec_t            mem [DEPTH];
  id_dec_t            dec_w;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               rdy_q;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  riscv_id_dec u_dec (
    .i_instr (i_instr),
    .i_pc    (i_pc),
    .o_dec   (dec_w)
  );

  // rdy_q keeps o_instr_ready low throughout reset and releases it on the first edge after.
  assign o_instr_ready = rdy_q && (count != CNT_W'(DEPTH));
  assign o_valid       = (count != '0);
  assign push          = i_instr_valid && o_instr_ready;
  assign pop           = o_valid && i_ready;
  assign o_dec         = mem[rd_ptr];
  assign o_count       = count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= dec_w;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_id_queue.sv
// Bench for riscv_id_queue: queue-based reference model checked every cycle,
// plus directed literal checks of individual decoded fields.
module tb_riscv_id_queue;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_instr_valid = 1'b0;
  logic        o_instr_ready;
  logic [31:0] i_instr = '0;
  logic [31:0] i_pc = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  id_dec_t     o_dec;
  logic [2:0]  o_count;

  int total = 0;
  int bad   = 0;

  id_dec_t mq[$];
  bit      mready = 1'b0;

  riscv_id_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_instr       (i_instr),
    .i_pc          (i_pc),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_dec         (o_dec),
    .o_count       (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Reference decode assembled from the RV32I immediate bit-placement rules.
  function automatic id_dec_t model_dec(input logic [31:0] w, input logic [31:0] pc);
    id_dec_t     base;
    id_dec_t     d;
    logic [31:0] hi;
    logic [31:0] imm;
    bit          legal;
    bit          wr;
    base           = '0;
    base.pc        = pc;
    base.opcode    = w[6:0];
    base.funct3    = w[14:12];
    base.funct7    = w[31:25];
    base.src1_addr = w[19:15];
    base.src2_addr = w[24:20];
    base.dst_addr  = w[11:7];
    d     = base;
    hi    = w[31] ? 32'hFFFFF000 : 32'h0;
    imm   = 32'h0;
    legal = 1'b1;
    wr    = 1'b0;
    case (w[6:0])
      7'h37, 7'h17: begin imm = w & 32'hFFFFF000; wr = 1; d.alures2reg = 1; end
      7'h6F: begin
        imm = (w[31] ? 32'hFFF00000 : 32'h0) | (w & 32'h000FF000) |
              (((w >> 20) & 32'h1) << 11) | (((w >> 21) & 32'h3FF) << 1);
        wr = 1; d.jal = 1;
      end
      7'h67: begin imm = hi | (w >> 20); wr = 1; d.src_en = 2'b01; d.jalr = 1; end
      7'h03: begin imm = hi | (w >> 20); wr = 1; d.src_en = 2'b01; d.memory2reg = 1; end
      7'h13: begin imm = hi | (w >> 20); wr = 1; d.src_en = 2'b01; d.alures2reg = 1; end
      7'h63: begin
        imm = hi | (((w >> 7) & 32'h1) << 11) | (((w >> 25) & 32'h3F) << 5) |
              (((w >> 8) & 32'hF) << 1);
        d.src_en = 2'b11; d.branch = 1;
      end
      7'h23: begin
        imm = hi | (((w >> 25) & 32'h7F) << 5) | ((w >> 7) & 32'h1F);
        d.src_en = 2'b11; d.mem_write = 1;
      end
      7'h33: begin
        if (w[31:25] == 7'd1) begin
`ifdef RISCV_ID_MEXT_EN
          wr = 1; d.src_en = 2'b11; d.alures2reg = 1; d.muldiv = 1;
`else
          legal = 0;
`endif
        end else begin
          wr = 1; d.src_en = 2'b11; d.alures2reg = 1;
        end
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      d = base;
      d.illegal = 1'b1;
    end else begin
      d.imm_num = imm;
      d.dst_en  = wr && (w[11:7] != 5'd0);
    end
    return d;
  endfunction

  initial begin : model
    bit pu;
    bit po;
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      if (!i_rst_n) begin
        mq.delete();
        mready = 1'b0;
      end else begin
        pu = i_instr_valid && mready && (mq.size() < DEPTH);
        po = (mq.size() != 0) && i_ready;
        if (i_flush) mq.delete();
        else begin
          if (po) void'(mq.pop_front());
          if (pu) mq.push_back(model_dec(i_instr, i_pc));
        end
        mready = 1'b1;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge i_clk);
      chk("valid", o_valid, mq.size() != 0);
      chk("count", o_count, mq.size());
      chk("ready", o_instr_ready, mready && (mq.size() != DEPTH));
      if (mq.size() != 0) begin
        total++;
        if (o_dec !== mq[0]) begin
          bad++;
          $display("FAIL dec got=%h want=%h", o_dec, mq[0]);
        end
      end
    end
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] w, input logic [31:0] pc, input logic rdy);
    i_instr_valid = 1'b1;
    i_instr       = w;
    i_pc          = pc;
    i_ready       = rdy;
    step();
    i_instr_valid = 1'b0;
  endtask

  logic [31:0] mix [10] = '{32'h123450b7, 32'h00001197, 32'hfe208ee3, 32'h00112423,
                            32'h002081b3, 32'h000080e7, 32'h0000000f, 32'h00000013,
                            32'h40208133, 32'hffdff06f};

  initial begin : stim
    repeat (3) step();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_instr_ready, 1'b0);
    chk("rst_count", o_count, 3'd0);
    i_rst_n = 1'b1;
    step();
    chk("ready_after_rst", o_instr_ready, 1'b1);

    push1(32'h00500093, 32'h100, 1'b1);
    chk("addi_valid", o_valid, 1'b1);
    chk("addi_imm", o_dec.imm_num, 32'd5);
    chk("addi_rd", o_dec.dst_addr, 5'd1);
    chk("addi_dst_en", o_dec.dst_en, 1'b1);
    chk("addi_src_en", o_dec.src_en, 2'b01);
    chk("addi_pc", o_dec.pc, 32'h100);
    step();

    push1(32'hffc12283, 32'h104, 1'b0);
    chk("lw_imm", o_dec.imm_num, 32'hFFFFFFFC);
    chk("lw_m2r", o_dec.memory2reg, 1'b1);
    chk("lw_rs1", o_dec.src1_addr, 5'd2);
    chk("lw_rd", o_dec.dst_addr, 5'd5);
    push1(32'h008000ef, 32'h108, 1'b0);
    i_ready = 1'b1;
    step();
    chk("jal_flag", o_dec.jal, 1'b1);
    chk("jal_imm", o_dec.imm_num, 32'd8);
    step();
    chk("empty_valid", o_valid, 1'b0);

    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_instr_valid = 1'b1;
      i_instr       = 32'h00100093 + (32'(k) << 20);
      i_pc          = 32'h200 + 32'(4 * k);
      step();
      if (k == 3) begin
        chk("full_count", o_count, 3'd4);
        chk("full_ready", o_instr_ready, 1'b0);
      end
    end
    i_instr_valid = 1'b0;
    chk("full_head_pc", o_dec.pc, 32'h200);
    i_ready = 1'b1;
    step();
    chk("pop_order_pc", o_dec.pc, 32'h204);
    repeat (3) step();
    chk("drained_count", o_count, 3'd0);

    i_ready = 1'b0;
    push1(32'h00a00093, 32'h280, 1'b0);
    push1(32'h00b00093, 32'h284, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push1(32'h00c00093 + (32'(k) << 20), 32'h288 + 32'(4 * k), 1'b1);
      chk("pushpop_count", o_count, 3'd2);
    end
    i_ready = 1'b1;
    repeat (2) step();

    i_ready = 1'b0;
    push1(32'h00100093, 32'h2c0, 1'b0);
    push1(32'h00200093, 32'h2c4, 1'b0);
    push1(32'h00300093, 32'h2c8, 1'b0);
    chk("pre_flush_count", o_count, 3'd3);
    i_flush = 1'b1;
    push1(32'h00400093, 32'h2cc, 1'b1);
    i_flush = 1'b0;
    i_ready = 1'b0;
    chk("flush_count", o_count, 3'd0);
    chk("flush_valid", o_valid, 1'b0);

    push1(32'h022081b3, 32'h300, 1'b0);
`ifdef RISCV_ID_MEXT_EN
    chk("mul_illegal", o_dec.illegal, 1'b0);
    chk("mul_muldiv", o_dec.muldiv, 1'b1);
`else
    chk("mul_illegal", o_dec.illegal, 1'b1);
    chk("mul_muldiv", o_dec.muldiv, 1'b0);
`endif
    push1(32'h00000000, 32'h304, 1'b0);
    i_ready = 1'b1;
    step();
    chk("zero_illegal", o_dec.illegal, 1'b1);
    chk("zero_src_en", o_dec.src_en, 2'b00);
    step();

    for (int k = 0; k < 10; k++) begin
      push1(mix[k], 32'h500 + 32'(4 * k), (k % 3) != 0);
    end
    i_ready = 1'b1;
    repeat (6) step();
    chk("mix_drained", o_count, 3'd0);

    i_ready = 1'b0;
    push1(32'h00100093, 32'h600, 1'b0);
    push1(32'h00200093, 32'h604, 1'b0);
    chk("pre_rst_count", o_count, 3'd2);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_valid", o_valid, 1'b0);
    chk("async_ready", o_instr_ready, 1'b0);
    chk("async_count", o_count, 3'd0);
    step();
    i_rst_n = 1'b1;
    step();
    chk("rerst_ready", o_instr_ready, 1'b1);
    push1(32'h00500093, 32'h700, 1'b1);
    chk("rerst_valid", o_valid, 1'b1);
    chk("rerst_pc", o_dec.pc, 32'h700);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
